param_crossbar: RTL

PARAM_CROSSBAR -- requirements
Module: param_crossbar

---
 rtl/rmt_act_pkg.sv | 43 ++++
 rtl/xbar_lane.sv | 81 ++++++++
 rtl/param_crossbar.sv | 113 +++++++++++
 3 files changed

// File: rtl/rmt_act_pkg.sv
// Shared action-slot field layout, opcodes and container widths for the RMT crossbar.
package rmt_act_pkg;

  localparam int W6B     = 48;
  localparam int W4B     = 32;
  localparam int W2B     = 16;
  localparam int IMM_W   = 16;
  localparam int IDX_W   = 3;
  localparam int MAX_CNT = 8;

  localparam int OPC_HI  = 24;
  localparam int OPC_LO  = 21;
  localparam int IDX1_HI = 18;
  localparam int IDX1_LO = 16;
  localparam int IDX2_HI = 13;
  localparam int IDX2_LO = 11;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  localparam logic [3:0] OPC_ADD   = 4'b0001;
  localparam logic [3:0] OPC_SUB   = 4'b0010;
  localparam logic [3:0] OPC_SET   = 4'b1000;
  localparam logic [3:0] OPC_ADDI  = 4'b1001;
  localparam logic [3:0] OPC_SUBI  = 4'b1010;
  localparam logic [3:0] OPC_LOADD = 4'b1011;

  typedef enum logic [1:0] {
    SEL_OWN     = 2'd0,
    SEL_REG_REG = 2'd1,
    SEL_REG_IMM = 2'd2
  } sel_mode_t;

  // 1000/1011 only take the immediate path in lanes that allow it (4B class).
  function automatic sel_mode_t decode_mode(input logic [3:0] opc, input logic allow_4b_imm);
    case (opc)
      OPC_ADD, OPC_SUB:    decode_mode = SEL_REG_REG;
      OPC_ADDI, OPC_SUBI:  decode_mode = SEL_REG_IMM;
      OPC_SET, OPC_LOADD:  decode_mode = allow_4b_imm ? SEL_REG_IMM : SEL_OWN;
      default:             decode_mode = SEL_OWN;
    endcase
  endfunction

endpackage

// File: rtl/xbar_lane.sv
// Per-container operand selection for one container width class (purely combinational).
module xbar_lane
  import rmt_act_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int COUNT           = 8,
  parameter bit ALLOW_1000_1011 = 1'b0,
  parameter int ACT_LEN         = 25
) (
  input  logic [WIDTH*COUNT-1:0]   containers,
  input  logic [ACT_LEN*COUNT-1:0] actions,
  output logic [WIDTH*COUNT-1:0]   op1,
  output logic [WIDTH*COUNT-1:0]   op2,
  output logic                     err
);

  // Padded to the full index range so a 3-bit index never reads past the array.
  logic [WIDTH-1:0] c_arr [MAX_CNT];
  logic [COUNT-1:0] errs;

  for (genvar j = 0; j < MAX_CNT; j++) begin : g_pad
    if (j < COUNT) begin : g_live
      assign c_arr[j] = containers[WIDTH*j +: WIDTH];
    end else begin : g_zero
      assign c_arr[j] = '0;
    end
  end

  for (genvar i = 0; i < COUNT; i++) begin : g_sel
    logic [ACT_LEN-1:0] slot;
    logic [IDX_W-1:0]   idx1;
    logic [IDX_W-1:0]   idx2;
    logic [IDX_W-1:0]   sel1;
    logic [IDX_W-1:0]   sel2;
    logic [IMM_W-1:0]   imm;
    logic               bad1;
    logic               bad2;
    logic               unused_slot;
    sel_mode_t          mode;
    logic [WIDTH-1:0]   o1;
    logic [WIDTH-1:0]   o2;
    logic               e;

    assign slot        = actions[ACT_LEN*i +: ACT_LEN];
    assign unused_slot = ^slot;
    assign mode        = decode_mode(slot[OPC_HI:OPC_LO], ALLOW_1000_1011);
    assign idx1        = slot[IDX1_HI:IDX1_LO];
    assign idx2        = slot[IDX2_HI:IDX2_LO];
    assign imm         = slot[IMM_HI:IMM_LO];
    assign bad1        = 32'(idx1) >= 32'(COUNT);
    assign bad2        = 32'(idx2) >= 32'(COUNT);
    assign sel1        = bad1 ? '0 : idx1;
    assign sel2        = bad2 ? '0 : idx2;

    always_comb begin
      o1 = c_arr[i];
      o2 = '0;
      e  = 1'b0;
      case (mode)
        SEL_REG_REG: begin
          o1 = c_arr[sel1];
          o2 = c_arr[sel2];
          e  = bad1 | bad2;
        end
        SEL_REG_IMM: begin
          o1 = c_arr[sel1];
          o2 = WIDTH'(imm);
          e  = bad1;
        end
        default: ;
      endcase
    end

    assign op1[WIDTH*i +: WIDTH] = o1;
    assign op2[WIDTH*i +: WIDTH] = o2;
    assign errs[i]               = e;
  end

  assign err = |errs;

endmodule

// File: rtl/param_crossbar.sv
// PHV operand crossbar: slices containers per class, selects ALU operands, one registered stage.
module param_crossbar
  import rmt_act_pkg::*;
#(
  parameter int N6      = 8,
  parameter int N4      = 8,
  parameter int N2      = 8,
  parameter int REM_LEN = 356,
  parameter int ACT_LEN = 25,
  localparam int NSLOT   = N6 + N4 + N2 + 1,
  localparam int PHV_LEN = W6B*N6 + W4B*N4 + W2B*N2 + REM_LEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PHV_LEN-1:0]       phv_in,
  input  logic                     phv_in_valid,
  input  logic [ACT_LEN*NSLOT-1:0] action_in,
  input  logic                     action_in_valid,
  output logic                     in_ready,
  output logic [W6B*N6-1:0]        alu_6B_1,
  output logic [W6B*N6-1:0]        alu_6B_2,
  output logic [W4B*N4-1:0]        alu_4B_1,
  output logic [W4B*N4-1:0]        alu_4B_2,
  output logic [W4B*N4-1:0]        alu_4B_3,
  output logic [W2B*N2-1:0]        alu_2B_1,
  output logic [W2B*N2-1:0]        alu_2B_2,
  output logic [REM_LEN-1:0]       phv_remain,
  output logic [ACT_LEN*NSLOT-1:0] action_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     idx_err,
  output logic [31:0]              accept_cnt
);

  localparam int BASE_2B = REM_LEN;
  localparam int BASE_4B = BASE_2B + W2B*N2;
  localparam int BASE_6B = BASE_4B + W4B*N4;
  localparam int SLOT_2B = 1;
  localparam int SLOT_4B = SLOT_2B + N2;
  localparam int SLOT_6B = SLOT_4B + N4;

  logic [W6B*N6-1:0] op1_6b, op2_6b;
  logic [W4B*N4-1:0] op1_4b, op2_4b;
  logic [W2B*N2-1:0] op1_2b, op2_2b;
  logic              err_6b, err_4b, err_2b;
  logic              accept;

  // Valid/ready: a beat moves on a rising clk edge where its valid and ready are both high.
  // The input side joins both valids; in_ready is combinational so the stage streams bubble-free.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = phv_in_valid & action_in_valid & in_ready;

  for (genvar cls = 0; cls < 3; cls++) begin : g_class
    if (cls == 0) begin : g_6b
      xbar_lane #(.WIDTH(W6B), .COUNT(N6), .ALLOW_1000_1011(1'b0), .ACT_LEN(ACT_LEN)) u_lane (
        .containers (phv_in[BASE_6B +: W6B*N6]),
        .actions    (action_in[ACT_LEN*SLOT_6B +: ACT_LEN*N6]),
        .op1        (op1_6b),
        .op2        (op2_6b),
        .err        (err_6b)
      );
    end else if (cls == 1) begin : g_4b
      xbar_lane #(.WIDTH(W4B), .COUNT(N4), .ALLOW_1000_1011(1'b1), .ACT_LEN(ACT_LEN)) u_lane (
        .containers (phv_in[BASE_4B +: W4B*N4]),
        .actions    (action_in[ACT_LEN*SLOT_4B +: ACT_LEN*N4]),
        .op1        (op1_4b),
        .op2        (op2_4b),
        .err        (err_4b)
      );
    end else begin : g_2b
      xbar_lane #(.WIDTH(W2B), .COUNT(N2), .ALLOW_1000_1011(1'b0), .ACT_LEN(ACT_LEN)) u_lane (
        .containers (phv_in[BASE_2B +: W2B*N2]),
        .actions    (action_in[ACT_LEN*SLOT_2B +: ACT_LEN*N2]),
        .op1        (op1_2b),
        .op2        (op2_2b),
        .err        (err_2b)
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      idx_err    <= 1'b0;
      accept_cnt <= '0;
      alu_6B_1   <= '0;
      alu_6B_2   <= '0;
      alu_4B_1   <= '0;
      alu_4B_2   <= '0;
      alu_4B_3   <= '0;
      alu_2B_1   <= '0;
      alu_2B_2   <= '0;
      phv_remain <= '0;
      action_out <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      idx_err    <= idx_err | err_6b | err_4b | err_2b;
      accept_cnt <= accept_cnt + 32'd1;
      alu_6B_1   <= op1_6b;
      alu_6B_2   <= op2_6b;
      alu_4B_1   <= op1_4b;
      alu_4B_2   <= op2_4b;
      alu_4B_3   <= phv_in[BASE_4B +: W4B*N4];
      alu_2B_1   <= op1_2b;
      alu_2B_2   <= op2_2b;
      phv_remain <= phv_in[REM_LEN-1:0];
      action_out <= action_in;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
